mem_arbiter: RTL and testbench

//  Shares the single 1 MiB byte-wide synchronous RAM port between the cpu86 core and a video fetch requester.

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/mem_arb_fair.sv | 43 ++++
 rtl/mem_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_arbiter.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings and defaults for the cpu86/video RAM port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_VID  = 2'd2
  } owner_t;

  localparam int VID_MAX_DEFAULT = 4;

  // Bits needed to hold a counter that saturates at max_val.
  function automatic int cnt_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_arb_fair.sv
// Grant decision for the shared RAM port: video first, with a saturating
// count of consecutive video wins that hands the port to a waiting CPU.
module mem_arb_fair
  import mem_arb_pkg::*;
#(
  parameter int VID_MAX = VID_MAX_DEFAULT
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_cpu_req,
  input  logic i_vid_req,
  input  logic i_sample,
  output logic o_grant_cpu,
  output logic o_grant_vid
);

  localparam int CW = cnt_width(VID_MAX);
  localparam logic [CW-1:0] W_MAX = CW'(VID_MAX);

  logic [CW-1:0] r_cnt;
  logic          w_cnt_full;

  assign w_cnt_full = (r_cnt == W_MAX);

  always_comb begin
    o_grant_vid = i_sample && i_vid_req && (!i_cpu_req || !w_cnt_full);
    o_grant_cpu = i_sample && i_cpu_req && !o_grant_vid;
  end

  // The count only measures video wins over a CPU that is actually waiting.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_sample) begin
      if (!i_cpu_req || o_grant_cpu) begin
        r_cnt <= '0;
      end else if (o_grant_vid && !w_cnt_full) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises cpu86 and video accesses onto one synchronous byte-wide RAM port,
// hiding the RAM's one-cycle read latency behind a req/ready handshake.
//
// Handshake: a requester raises req with address/we/data and holds it until it
// sees ready high for one cycle; the request fields are latched at grant, and
// a req still high in the next IDLE cycle starts a new transaction.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 20,
  parameter int DW      = 8,
  parameter int VID_MAX = VID_MAX_DEFAULT
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_address,
  input  logic [DW-1:0] cpu_dout,
  output logic [DW-1:0] cpu_din,
  output logic          cpu_ready,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_address,
  output logic [DW-1:0] vid_data,
  output logic          vid_ready,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_dout,
  output logic          mem_we,
  input  logic [DW-1:0] mem_din,
  output logic [1:0]    dbg_state
);

  state_t        r_state;
  state_t        w_next_state;
  owner_t        r_owner;
  logic          r_is_wr;
  logic [AW-1:0] r_mem_address;
  logic [DW-1:0] r_mem_dout;
  logic          r_mem_we;
  logic [DW-1:0] r_cpu_din;
  logic          r_cpu_ready;
  logic [DW-1:0] r_vid_data;
  logic          r_vid_ready;
  logic          w_sample;
  logic          w_grant_cpu;
  logic          w_grant_vid;

  assign w_sample = (r_state == ST_IDLE);

  mem_arb_fair #(
    .VID_MAX(VID_MAX)
  ) u_fair (
    .i_clock    (clock),
    .i_reset    (reset),
    .i_cpu_req  (cpu_req),
    .i_vid_req  (vid_req),
    .i_sample   (w_sample),
    .o_grant_cpu(w_grant_cpu),
    .o_grant_vid(w_grant_vid)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_grant_cpu || w_grant_vid) w_next_state = ST_ADDR;
      ST_ADDR: w_next_state = r_is_wr ? ST_DONE : ST_DATA;
      ST_DATA: w_next_state = ST_DONE;
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // mem_we and both ready outputs are single-cycle pulses, cleared by default.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_owner       <= OWN_NONE;
      r_is_wr       <= 1'b0;
      r_mem_address <= '0;
      r_mem_dout    <= '0;
      r_mem_we      <= 1'b0;
      r_cpu_din     <= '0;
      r_cpu_ready   <= 1'b0;
      r_vid_data    <= '0;
      r_vid_ready   <= 1'b0;
    end else begin
      r_mem_we    <= 1'b0;
      r_cpu_ready <= 1'b0;
      r_vid_ready <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant_cpu) begin
            r_mem_address <= cpu_address;
            r_mem_dout    <= cpu_dout;
            r_mem_we      <= cpu_we;
            r_is_wr       <= cpu_we;
            r_owner       <= OWN_CPU;
          end else if (w_grant_vid) begin
            r_mem_address <= vid_address;
            r_is_wr       <= 1'b0;
            r_owner       <= OWN_VID;
          end
        end
        ST_ADDR: begin
          if (r_is_wr && r_owner == OWN_CPU) r_cpu_ready <= 1'b1;
        end
        ST_DATA: begin
          if (r_owner == OWN_CPU) begin
            r_cpu_din   <= mem_din;
            r_cpu_ready <= 1'b1;
          end else if (r_owner == OWN_VID) begin
            r_vid_data  <= mem_din;
            r_vid_ready <= 1'b1;
          end
        end
        ST_DONE: r_owner <= OWN_NONE;
        default: r_owner <= OWN_NONE;
      endcase
    end
  end

  assign mem_address = r_mem_address;
  assign mem_dout    = r_mem_dout;
  assign mem_we      = r_mem_we;
  assign cpu_din     = r_cpu_din;
  assign cpu_ready   = r_cpu_ready;
  assign vid_data    = r_vid_data;
  assign vid_ready   = r_vid_ready;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural byte RAM, directed latency/arbitration
// scenarios and a randomized two-requester run against a memory model.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW      = 20;
  localparam int DW      = 8;
  localparam int VID_MAX = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we, vid_req;
  logic [AW-1:0] cpu_address, vid_address, mem_address;
  logic [DW-1:0] cpu_dout, cpu_din, vid_data, mem_dout, mem_din;
  logic          cpu_ready, vid_ready, mem_we;
  logic [1:0]    dbg_state;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] model_mem [int];
  logic [AW-1:0] cpu_pool [8];
  logic [AW-1:0] vid_pool [8];

  always #5 clock = ~clock;

  mem_arbiter #(.AW(AW), .DW(DW), .VID_MAX(VID_MAX)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_address(cpu_address),
    .cpu_dout(cpu_dout), .cpu_din(cpu_din), .cpu_ready(cpu_ready),
    .vid_req(vid_req), .vid_address(vid_address), .vid_data(vid_data),
    .vid_ready(vid_ready), .mem_address(mem_address), .mem_dout(mem_dout),
    .mem_we(mem_we), .mem_din(mem_din), .dbg_state(dbg_state)
  );

  // Synchronous RAM, read-before-write, plus a backdoor preload port.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic          bd_we = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [DW-1:0] bd_data = '0;

  always @(posedge clock) begin
    mem_din <= ram[mem_address];
    if (mem_we) ram[mem_address] <= mem_dout;
    if (bd_we) ram[bd_addr] <= bd_data;
  end

  // Sticky protocol monitor: ready outputs exclusive, mem_we never two cycles.
  logic mon_viol = 1'b0;
  logic prev_we  = 1'b0;
  always @(negedge clock) begin
    if (reset) begin
      prev_we <= 1'b0;
    end else begin
      if (cpu_ready && vid_ready) mon_viol <= 1'b1;
      if (mem_we && prev_we) mon_viol <= 1'b1;
      prev_we <= mem_we;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic preload(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    bd_addr = addr;
    bd_data = data;
    bd_we   = 1'b1;
    @(posedge clock);
    #1;
    bd_we = 1'b0;
    model_mem[int'(addr)] = data;
  endtask

  // Runs one CPU access; lat counts posedges from the call to the ready pulse.
  task automatic do_cpu(input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] data, input bit move_addr,
                        input logic [AW-1:0] new_addr, output logic [DW-1:0] rd,
                        output int lat, output int we_cycles,
                        output logic [AW-1:0] we_addr, output bit vid_seen);
    cpu_we = we; cpu_address = addr; cpu_dout = data; cpu_req = 1'b1;
    rd = '0; lat = 0; we_cycles = 0; we_addr = '0; vid_seen = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clock);
      #1;
      if (move_addr && k == 1) cpu_address = new_addr;
      if (mem_we) begin
        we_cycles++;
        we_addr = mem_address;
      end
      if (vid_ready) vid_seen = 1'b1;
      if (cpu_ready) begin
        lat = k;
        rd  = cpu_din;
        break;
      end
    end
    cpu_req = 1'b0;
  endtask

  task automatic do_vid(input logic [AW-1:0] addr, output logic [DW-1:0] rd,
                        output int lat, output bit cpu_seen, output int we_cycles);
    vid_address = addr; vid_req = 1'b1;
    rd = '0; lat = 0; cpu_seen = 1'b0; we_cycles = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clock);
      #1;
      if (mem_we) we_cycles++;
      if (cpu_ready) cpu_seen = 1'b1;
      if (vid_ready) begin
        lat = k;
        rd  = vid_data;
        break;
      end
    end
    vid_req = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_address = '0; cpu_dout = '0;
    vid_req = 0; vid_address = '0;
    idle(3);
    reset = 1'b0;
    idle(2);
    checks++; if (mem_address !== '0) begin failures++; $display("FAIL reset_mem_address got=%h exp=0", mem_address); end
    checks++; if (mem_dout !== '0) begin failures++; $display("FAIL reset_mem_dout got=%h exp=0", mem_dout); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
    checks++; if (cpu_din !== '0 || cpu_ready !== 1'b0) begin failures++; $display("FAIL reset_cpu got din=%h rdy=%b exp 0/0", cpu_din, cpu_ready); end
    checks++; if (vid_data !== '0 || vid_ready !== 1'b0) begin failures++; $display("FAIL reset_vid got data=%h rdy=%b exp 0/0", vid_data, vid_ready); end
    checks++; if (dbg_state !== 2'(ST_IDLE)) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, ST_IDLE); end
  endtask

  task automatic test_cpu_write_read();
    logic [DW-1:0] rd; int lat, wc; logic [AW-1:0] wa; bit vs;
    do_cpu(1'b1, 20'h12345, 8'h5A, 1'b0, '0, rd, lat, wc, wa, vs);
    checks++; if (lat !== 2) begin failures++; $display("FAIL wr_latency got=%0d exp=2", lat); end
    checks++; if (wc !== 1 || wa !== 20'h12345) begin failures++; $display("FAIL wr_mem_we got cycles=%0d addr=%h exp 1/12345", wc, wa); end
    checks++; if (ram[20'h12345] !== 8'h5A) begin failures++; $display("FAIL wr_ram got=%h exp=5a", ram[20'h12345]); end
    model_mem[32'h12345] = 8'h5A;
    idle(1);
    do_cpu(1'b0, 20'h12345, 8'h00, 1'b0, '0, rd, lat, wc, wa, vs);
    checks++; if (lat !== 3) begin failures++; $display("FAIL rd_latency got=%0d exp=3", lat); end
    checks++; if (rd !== 8'h5A) begin failures++; $display("FAIL rd_data got=%h exp=5a", rd); end
    checks++; if (wc !== 0 || vs) begin failures++; $display("FAIL rd_side got we_cycles=%0d vid_seen=%b exp 0/0", wc, vs); end
    idle(1);
  endtask

  task automatic test_video_read();
    logic [DW-1:0] rd; int lat, wc; bit cs; logic [DW-1:0] cpu_before;
    preload(20'hB8000, 8'h41);
    cpu_before = cpu_din;
    do_vid(20'hB8000, rd, lat, cs, wc);
    checks++; if (lat !== 3) begin failures++; $display("FAIL vid_latency got=%0d exp=3", lat); end
    checks++; if (rd !== 8'h41) begin failures++; $display("FAIL vid_data got=%h exp=41", rd); end
    checks++; if (cs || wc !== 0) begin failures++; $display("FAIL vid_side got cpu_ready_seen=%b we_cycles=%0d exp 0/0", cs, wc); end
    checks++; if (cpu_din !== cpu_before) begin failures++; $display("FAIL vid_cpu_din got=%h exp=%h", cpu_din, cpu_before); end
    idle(1);
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] rd; int lat, wc; logic [AW-1:0] wa; bit vs;
    int exp_lat [5] = '{2, 3, 3, 4, 4};
    logic ops_we [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [DW-1:0] wr_data [3];
    for (int i = 0; i < 3; i++) wr_data[i] = DW'($urandom_range(0, 255));
    for (int i = 0; i < 5; i++) begin
      if (ops_we[i]) begin
        do_cpu(1'b1, 20'h00200 + AW'(i), wr_data[i], 1'b0, '0, rd, lat, wc, wa, vs);
        model_mem[32'h200 + i] = wr_data[i];
      end else begin
        do_cpu(1'b0, 20'h00200 + AW'(i - 3), 8'h00, 1'b0, '0, rd, lat, wc, wa, vs);
        checks++; if (rd !== model_mem[32'h200 + i - 3]) begin failures++; $display("FAIL b2b_data op=%0d got=%h exp=%h", i, rd, model_mem[32'h200 + i - 3]); end
      end
      checks++; if (lat !== exp_lat[i]) begin failures++; $display("FAIL b2b_latency op=%0d got=%0d exp=%0d", i, lat, exp_lat[i]); end
    end
    idle(1);
  endtask

  task automatic test_addr_change();
    logic [DW-1:0] rd; int lat, wc; logic [AW-1:0] wa; bit vs;
    preload(20'h00010, 8'h00);
    preload(20'h00020, 8'h00);
    do_cpu(1'b1, 20'h00010, 8'hC3, 1'b1, 20'h00020, rd, lat, wc, wa, vs);
    checks++; if (wa !== 20'h00010) begin failures++; $display("FAIL addr_hold_we got=%h exp=00010", wa); end
    checks++; if (ram[20'h00010] !== 8'hC3 || ram[20'h00020] !== 8'h00) begin
      failures++; $display("FAIL addr_hold_ram got 10=%h 20=%h exp c3/00", ram[20'h00010], ram[20'h00020]);
    end
    idle(1);
    do_cpu(1'b0, 20'h00010, 8'h00, 1'b1, 20'h00020, rd, lat, wc, wa, vs);
    checks++; if (rd !== 8'hC3) begin failures++; $display("FAIL addr_hold_rd got=%h exp=c3", rd); end
    idle(1);
  endtask

  task automatic test_fairness();
    logic [7:0] got_q [$];
    logic [7:0] exp_q [$];
    int cnt, run, max_run;
    bit data_ok;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (cnt < VID_MAX) begin exp_q.push_back("V"); cnt++; end
      else begin exp_q.push_back("C"); cnt = 0; end
    end
    data_ok = 1'b1;
    cpu_we = 1'b0; cpu_address = 20'h12345;
    vid_address = 20'hB8000;
    cpu_req = 1'b1; vid_req = 1'b1;
    for (int k = 0; k < 200 && got_q.size() < 10; k++) begin
      @(posedge clock);
      #1;
      if (vid_ready) begin got_q.push_back("V"); if (vid_data !== 8'h41) data_ok = 1'b0; end
      if (cpu_ready) begin got_q.push_back("C"); if (cpu_din !== 8'h5A) data_ok = 1'b0; end
    end
    cpu_req = 1'b0; vid_req = 1'b0;
    checks++; if (got_q.size() !== 10) begin failures++; $display("FAIL fair_count got=%0d exp=10", got_q.size()); end
    for (int i = 0; i < 10 && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL fair_order idx=%0d got=%s exp=%s", i, got_q[i], exp_q[i]); end
    end
    checks++; if (!data_ok) begin failures++; $display("FAIL fair_data got=bad exp=cpu 5a vid 41"); end
    run = 0; max_run = 0;
    foreach (got_q[i]) begin
      if (got_q[i] == "V") run++; else run = 0;
      if (run > max_run) max_run = run;
    end
    checks++; if (max_run > VID_MAX) begin failures++; $display("FAIL fair_starve got=%0d exp<=%0d", max_run, VID_MAX); end
    idle(2);
  endtask

  task automatic test_simultaneous();
    logic [DW-1:0] vrd, crd; int vlat, clat, vwc, cwc; logic [AW-1:0] wa; bit cs, vs;
    fork
      do_vid(20'hB8000, vrd, vlat, cs, vwc);
      do_cpu(1'b0, 20'h12345, 8'h00, 1'b0, '0, crd, clat, cwc, wa, vs);
    join
    checks++; if (vlat !== 3 || vrd !== 8'h41) begin failures++; $display("FAIL simul_vid got lat=%0d data=%h exp 3/41", vlat, vrd); end
    checks++; if (clat !== 7 || crd !== 8'h5A) begin failures++; $display("FAIL simul_cpu got lat=%0d data=%h exp 7/5a", clat, crd); end
    checks++; if (cs) begin failures++; $display("FAIL simul_order got=cpu_before_vid exp=vid_first"); end
    idle(1);
  endtask

  task automatic watch_quiet(input string name);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clock);
      #1;
      if (cpu_ready || vid_ready || mem_we) seen = 1'b1;
    end
    checks++; if (seen) begin failures++; $display("FAIL %s_quiet got=activity exp=none", name); end
  endtask

  task automatic test_reset_mid();
    preload(20'h00040, 8'h11);
    cpu_we = 1'b1; cpu_address = 20'h00040; cpu_dout = 8'h99; cpu_req = 1'b1;
    idle(1);
    checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL rst_wr_pre got mem_we=%b exp=1", mem_we); end
    reset = 1'b1;
    #1;
    checks++; if (mem_we !== 1'b0 || cpu_ready !== 1'b0 || vid_ready !== 1'b0 || dbg_state !== 2'(ST_IDLE)) begin
      failures++; $display("FAIL rst_wr_now got we=%b crdy=%b vrdy=%b st=%0d exp 0/0/0/0", mem_we, cpu_ready, vid_ready, dbg_state);
    end
    cpu_req = 1'b0;
    idle(1);
    reset = 1'b0;
    watch_quiet("rst_wr");
    checks++; if (ram[20'h00040] !== 8'h11) begin failures++; $display("FAIL rst_wr_ram got=%h exp=11", ram[20'h00040]); end

    cpu_we = 1'b0; cpu_address = 20'h12345; cpu_req = 1'b1;
    idle(2);
    checks++; if (dbg_state !== 2'(ST_DATA)) begin failures++; $display("FAIL rst_rd_pre got st=%0d exp=%0d", dbg_state, ST_DATA); end
    reset = 1'b1;
    #1;
    checks++; if (mem_we !== 1'b0 || cpu_ready !== 1'b0 || cpu_din !== '0 || dbg_state !== 2'(ST_IDLE)) begin
      failures++; $display("FAIL rst_rd_now got we=%b crdy=%b din=%h st=%0d exp 0/0/00/0", mem_we, cpu_ready, cpu_din, dbg_state);
    end
    cpu_req = 1'b0;
    idle(1);
    reset = 1'b0;
    watch_quiet("rst_rd");
  endtask

  task automatic rand_cpu_stream();
    for (int i = 0; i < 24; i++) begin
      logic we; logic [AW-1:0] addr; logic [DW-1:0] data; bit done; int vcount;
      we = 1'($urandom_range(0, 1));
      addr = cpu_pool[$urandom_range(0, 7)];
      data = DW'($urandom_range(0, 255));
      cpu_we = we; cpu_address = addr; cpu_dout = data; cpu_req = 1'b1;
      done = 1'b0; vcount = 0;
      for (int k = 0; k < 60 && !done; k++) begin
        @(posedge clock);
        #1;
        if (vid_ready) vcount++;
        if (cpu_ready) done = 1'b1;
      end
      cpu_req = 1'b0;
      checks++; if (!done) begin failures++; $display("FAIL rand_cpu_timeout op=%0d got=no_ready exp=ready", i); end
      if (done && !we) begin
        checks++; if (cpu_din !== model_mem[int'(addr)]) begin failures++; $display("FAIL rand_cpu_data op=%0d addr=%h got=%h exp=%h", i, addr, cpu_din, model_mem[int'(addr)]); end
      end
      if (done && we) model_mem[int'(addr)] = data;
      checks++; if (vcount > VID_MAX + 1) begin failures++; $display("FAIL rand_cpu_starve op=%0d got=%0d exp<=%0d", i, vcount, VID_MAX + 1); end
      idle($urandom_range(0, 2));
    end
  endtask

  task automatic rand_vid_stream();
    for (int i = 0; i < 24; i++) begin
      logic [AW-1:0] addr; bit done;
      addr = vid_pool[$urandom_range(0, 7)];
      vid_address = addr; vid_req = 1'b1;
      done = 1'b0;
      for (int k = 0; k < 60 && !done; k++) begin
        @(posedge clock);
        #1;
        if (vid_ready) done = 1'b1;
      end
      vid_req = 1'b0;
      checks++; if (!done) begin failures++; $display("FAIL rand_vid_timeout op=%0d got=no_ready exp=ready", i); end
      if (done) begin
        checks++; if (vid_data !== model_mem[int'(addr)]) begin failures++; $display("FAIL rand_vid_data op=%0d addr=%h got=%h exp=%h", i, addr, vid_data, model_mem[int'(addr)]); end
      end
      idle($urandom_range(0, 3));
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      cpu_pool[i] = 20'h00100 + AW'(i * 'h1111);
      vid_pool[i] = 20'hB8100 + AW'(i * 2);
      preload(cpu_pool[i], DW'($urandom_range(0, 255)));
      preload(vid_pool[i], DW'($urandom_range(0, 255)));
    end
    fork
      rand_cpu_stream();
      rand_vid_stream();
    join
    idle(2);
    for (int i = 0; i < 8; i++) begin
      checks++; if (ram[cpu_pool[i]] !== model_mem[int'(cpu_pool[i])]) begin
        failures++; $display("FAIL rand_ram addr=%h got=%h exp=%h", cpu_pool[i], ram[cpu_pool[i]], model_mem[int'(cpu_pool[i])]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_cpu_write_read();
    test_video_read();
    test_back_to_back();
    test_addr_change();
    test_fairness();
    test_simultaneous();
    test_reset_mid();
    test_random();
    checks++; if (mon_viol !== 1'b0) begin failures++; $display("FAIL protocol_monitor got=violation exp=clean"); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
